// File: rtl/dmem_responder_pkg.sv
// Shared types and width helpers for the data-memory responder.
// Address layout: tag | line index | word index | byte offset.
package dmem_responder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRefillReq,
    StRefillWait,
    StResp,
    StWriteReq
  } state_e;

  localparam int unsigned DefLines        = 64;
  localparam int unsigned DefWordsPerLine = 4;
  localparam int unsigned OffsetW         = 2;

  function automatic int unsigned index_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned word_w(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int unsigned tag_w(input int unsigned lines, input int unsigned words_per_line);
    return 32 - OffsetW - $clog2(lines) - $clog2(words_per_line);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [3:0] mask,
                                              input logic [31:0] new_w);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core dcache port plus memory-arbiter request/response channel.
// slave is the responder's view; master is the core/arbiter side.
interface dmem_responder_if;
  logic [31:0] cpu_addr;
  logic        cpu_re;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        stall;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_wmask;
  logic [31:0] mem_req_data;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport slave (
    input  cpu_addr, cpu_re, cpu_we, cpu_din, mem_req_ready, mem_resp_valid, mem_resp_data,
    output cpu_dout, stall, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wmask, mem_req_data
  );

  modport master (
    output cpu_addr, cpu_re, cpu_we, cpu_din, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  cpu_dout, stall, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wmask, mem_req_data
  );
endinterface

// File: rtl/dmem_line_store.sv
// Direct-mapped line storage: flop-based data/tag/valid arrays with one byte-masked
// write port (store merge or refill beat) and a combinational lookup/hit port.
module dmem_line_store
  import dmem_responder_pkg::*;
#(
  parameter int unsigned LINES          = DefLines,
  parameter int unsigned WORDS_PER_LINE = DefWordsPerLine,
  localparam int unsigned IndexW        = index_w(LINES),
  localparam int unsigned WordW         = word_w(WORDS_PER_LINE),
  localparam int unsigned TagW          = tag_w(LINES, WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IndexW-1:0] lk_index_i,
  input  logic [WordW-1:0]  lk_word_i,
  input  logic [TagW-1:0]   lk_tag_i,
  output logic              hit_o,
  output logic [31:0]       rdata_o,
  input  logic              wr_en_i,
  input  logic [IndexW-1:0] wr_index_i,
  input  logic [WordW-1:0]  wr_word_i,
  input  logic [3:0]        wr_mask_i,
  input  logic [31:0]       wr_data_i,
  input  logic              fill_en_i,
  input  logic [TagW-1:0]   fill_tag_i
);

  logic [31:0]      data_q [LINES][WORDS_PER_LINE];
  logic [TagW-1:0]  tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Fill reuses the write-port index: the tag lands with the final refill beat.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[wr_index_i][wr_word_i] <=
          merge_bytes(data_q[wr_index_i][wr_word_i], wr_mask_i, wr_data_i);
    end
    if (fill_en_i) begin
      tag_q[wr_index_i] <= fill_tag_i;
    end
  end

  assign hit_o   = valid_q[lk_index_i] && (tag_q[lk_index_i] == lk_tag_i);
  assign rdata_o = data_q[lk_index_i][lk_word_i];

endmodule

// File: rtl/dmem_responder.sv
// Write-through, no-write-allocate direct-mapped data cache sitting between the
// core's dcache port and the memory arbiter; stalls the core on misses and stores.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned LINES          = DefLines,
  parameter int unsigned WORDS_PER_LINE = DefWordsPerLine
) (
  input logic               clk,
  input logic               reset,
  dmem_responder_if.slave   bus
);

  localparam int unsigned IndexW   = index_w(LINES);
  localparam int unsigned WordW    = word_w(WORDS_PER_LINE);
  localparam int unsigned TagW     = tag_w(LINES, WORDS_PER_LINE);
  localparam logic [31:0] WordMask = ~32'h3;
  localparam logic [31:0] LineMask = ~(32'(WORDS_PER_LINE * 4) - 32'd1);

  state_e            state_q;
  logic              stall_q;
  logic              req_valid_q;
  logic              req_we_q;
  logic [31:0]       req_addr_q;
  logic [3:0]        req_wmask_q;
  logic [31:0]       req_data_q;
  logic [31:0]       dout_q;
  logic [31:0]       capt_q;
  logic [IndexW-1:0] index_q;
  logic [WordW-1:0]  word_q;
  logic [WordW-1:0]  beat_q;
  logic [TagW-1:0]   tag_q;

  logic [IndexW-1:0] cpu_index;
  logic [WordW-1:0]  cpu_word;
  logic [TagW-1:0]   cpu_tag;
  logic              is_store;
  logic              accept;
  logic              refill_beat;
  logic              last_beat;
  logic              hit;
  logic [31:0]       rdata;
  logic              wr_en;
  logic [IndexW-1:0] wr_index;
  logic [WordW-1:0]  wr_word;
  logic [3:0]        wr_mask;
  logic [31:0]       wr_data;

  assign cpu_index   = bus.cpu_addr[OffsetW + WordW +: IndexW];
  assign cpu_word    = bus.cpu_addr[OffsetW +: WordW];
  assign cpu_tag     = bus.cpu_addr[31 -: TagW];
  assign is_store    = |bus.cpu_we;
  // stall_q is low only in StIdle and StResp, the two accepting states.
  assign accept      = !stall_q && (bus.cpu_re || is_store);
  assign refill_beat = (state_q == StRefillWait) && bus.mem_resp_valid;
  assign last_beat   = refill_beat && (beat_q == {WordW{1'b1}});

  always_comb begin
    wr_en    = accept && is_store && hit;
    wr_index = cpu_index;
    wr_word  = cpu_word;
    wr_mask  = bus.cpu_we;
    wr_data  = bus.cpu_din;
    if (state_q == StRefillWait) begin
      wr_en    = bus.mem_resp_valid;
      wr_index = index_q;
      wr_word  = beat_q;
      wr_mask  = 4'hF;
      wr_data  = bus.mem_resp_data;
    end
  end

  dmem_line_store #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_line_store (
    .clk        (clk),
    .reset      (reset),
    .lk_index_i (cpu_index),
    .lk_word_i  (cpu_word),
    .lk_tag_i   (cpu_tag),
    .hit_o      (hit),
    .rdata_o    (rdata),
    .wr_en_i    (wr_en),
    .wr_index_i (wr_index),
    .wr_word_i  (wr_word),
    .wr_mask_i  (wr_mask),
    .wr_data_i  (wr_data),
    .fill_en_i  (last_beat),
    .fill_tag_i (tag_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      stall_q     <= 1'b0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wmask_q <= '0;
      req_data_q  <= '0;
      dout_q      <= '0;
      capt_q      <= '0;
      index_q     <= '0;
      word_q      <= '0;
      beat_q      <= '0;
      tag_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle, StResp: begin
          state_q <= StIdle;
          if (accept) begin
            index_q <= cpu_index;
            word_q  <= cpu_word;
            tag_q   <= cpu_tag;
            if (is_store) begin
              req_valid_q <= 1'b1;
              req_we_q    <= 1'b1;
              req_addr_q  <= bus.cpu_addr & WordMask;
              req_wmask_q <= bus.cpu_we;
              req_data_q  <= bus.cpu_din;
              stall_q     <= 1'b1;
              state_q     <= StWriteReq;
            end else if (hit) begin
              dout_q <= rdata;
            end else begin
              req_valid_q <= 1'b1;
              req_we_q    <= 1'b0;
              req_addr_q  <= bus.cpu_addr & LineMask;
              req_wmask_q <= 4'h0;
              req_data_q  <= '0;
              stall_q     <= 1'b1;
              state_q     <= StRefillReq;
            end
          end
        end
        StRefillReq: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            beat_q      <= '0;
            state_q     <= StRefillWait;
          end
        end
        StRefillWait: begin
          if (refill_beat) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == word_q) capt_q <= bus.mem_resp_data;
            if (last_beat) begin
              dout_q  <= (beat_q == word_q) ? bus.mem_resp_data : capt_q;
              stall_q <= 1'b0;
              state_q <= StResp;
            end
          end
        end
        StWriteReq: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            stall_q     <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cpu_dout      = dout_q;
  assign bus.stall         = stall_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_we    = req_we_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wmask = req_wmask_q;
  assign bus.mem_req_data  = req_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a backing-memory model serves requests,
// and expected load data is queued at issue time and compared on completion.
module tb_dmem_responder;

  localparam int Wpl = 4;

  logic clk = 1'b0;
  logic reset;

  dmem_responder_if bus ();

  dmem_responder #(
    .LINES          (64),
    .WORDS_PER_LINE (Wpl)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] bmem  [logic [31:0]];  // memory side, updated by DUT write requests
  logic [31:0] model [logic [31:0]];  // expected contents, updated by stimulus
  logic [31:0] exp_q [$];

  logic [31:0] obs_dout, rd_addr, wr_addr, wr_data, snap_addr, snap_data, exp_w;
  logic [3:0]  wr_mask, snap_mask;
  logic        snap_we;
  int          n_rd, n_wr, stall_cycles;
  bit          unstable, timed_out, aborted;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a & ~32'h3) ^ 32'h5EED_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [3:0] m,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    logic [31:0] k;
    k = a & ~32'h3;
    if (bmem.exists(k)) return bmem[k];
    return dflt(k);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] k;
    k = a & ~32'h3;
    if (model.exists(k)) return model[k];
    return dflt(k);
  endfunction

  // Issue one request at a negedge and service the memory side until stall drops.
  task automatic do_op(input logic [31:0] addr, input logic re, input logic [3:0] we,
                       input logic [31:0] din, input int ready_delay, input int abort_beats);
    int          wait_cnt = 0;
    int          beats = 0;
    bit          rd_pending = 0;
    logic [31:0] rd_base = '0;
    n_rd = 0; n_wr = 0; stall_cycles = 0; unstable = 0; timed_out = 1; aborted = 0;
    obs_dout = 'x;
    bus.cpu_addr = addr; bus.cpu_re = re; bus.cpu_we = we; bus.cpu_din = din;
    @(negedge clk);
    bus.cpu_re = 1'b0; bus.cpu_we = 4'h0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (!bus.stall) begin
        timed_out = 0; obs_dout = bus.cpu_dout;
        break;
      end
      stall_cycles++;
      bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
      if (bus.mem_req_valid) begin
        if (wait_cnt == 0) begin
          snap_we = bus.mem_req_we; snap_addr = bus.mem_req_addr;
          snap_mask = bus.mem_req_wmask; snap_data = bus.mem_req_data;
        end else if ({bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wmask, bus.mem_req_data}
                     !== {snap_we, snap_addr, snap_mask, snap_data}) begin
          unstable = 1;
        end
        if (wait_cnt >= ready_delay) begin
          bus.mem_req_ready = 1'b1; wait_cnt = 0;
          if (bus.mem_req_we) begin
            n_wr++; wr_addr = bus.mem_req_addr; wr_mask = bus.mem_req_wmask;
            wr_data = bus.mem_req_data;
            bmem[bus.mem_req_addr & ~32'h3] = merge(bmem_rd(bus.mem_req_addr), wr_mask, wr_data);
          end else begin
            n_rd++; rd_addr = bus.mem_req_addr; rd_base = bus.mem_req_addr;
            rd_pending = 1; beats = 0;
          end
        end else begin
          wait_cnt++;
        end
      end else if (rd_pending) begin
        if (beats == abort_beats) begin
          aborted = 1; timed_out = 0;
          break;
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = bmem_rd(rd_base + 32'(4 * beats));
        beats++;
        if (beats == Wpl) rd_pending = 0;
      end
      @(negedge clk);
    end
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cpu_addr = '0; bus.cpu_re = 1'b0; bus.cpu_we = 4'h0; bus.cpu_din = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    n_vec++;
    if (bus.mem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_req_valid got %b want 0", bus.mem_req_valid);
    end
    n_vec++;
    if (bus.cpu_dout !== 32'h0) begin n_err++; $display("FAIL reset_dout got %h want 0", bus.cpu_dout); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_miss();
    exp_q.push_back(model_rd(32'h1004));
    do_op(32'h1004, 1'b1, 4'h0, '0, 0, -1);
    exp_w = exp_q.pop_front();
    n_vec++;
    if (obs_dout !== exp_w) begin n_err++; $display("FAIL miss_dout got %h want %h", obs_dout, exp_w); end
    n_vec++;
    if (n_rd !== 1 || rd_addr !== 32'h1000) begin
      n_err++; $display("FAIL miss_req got %0d reqs addr %h want 1 addr 00001000", n_rd, rd_addr);
    end
    n_vec++;
    if (stall_cycles !== 5 || n_wr !== 0) begin
      n_err++; $display("FAIL miss_stall got %0d cycles %0d writes want 5 0", stall_cycles, n_wr);
    end
    @(negedge clk);
    n_vec++;
    if (bus.cpu_dout !== exp_w) begin
      n_err++; $display("FAIL dout_hold got %h want %h", bus.cpu_dout, exp_w);
    end
  endtask

  task automatic test_load_hit();
    exp_q.push_back(model_rd(32'h1008));
    do_op(32'h1008, 1'b1, 4'h0, '0, 0, -1);
    exp_w = exp_q.pop_front();
    n_vec++;
    if (obs_dout !== exp_w) begin n_err++; $display("FAIL hit_dout got %h want %h", obs_dout, exp_w); end
    n_vec++;
    if (stall_cycles !== 0 || n_rd !== 0) begin
      n_err++; $display("FAIL hit_nostall got %0d cycles %0d reqs want 0 0", stall_cycles, n_rd);
    end
  endtask

  task automatic test_store_hit();
    model[32'h1008] = merge(model_rd(32'h1008), 4'b0100, 32'h00EE_0000);
    do_op(32'h1008, 1'b0, 4'b0100, 32'h00EE_0000, 0, -1);
    n_vec++;
    if (n_wr !== 1 || wr_addr !== 32'h1008 || n_rd !== 0) begin
      n_err++; $display("FAIL st_hit_req got %0d wr addr %h %0d rd want 1 00001008 0", n_wr, wr_addr, n_rd);
    end
    n_vec++;
    if (wr_mask !== 4'b0100 || wr_data !== 32'h00EE_0000) begin
      n_err++; $display("FAIL st_hit_fields got mask %b data %h want 0100 00ee0000", wr_mask, wr_data);
    end
    n_vec++;
    if (stall_cycles !== 1) begin n_err++; $display("FAIL st_hit_stall got %0d want 1", stall_cycles); end
    exp_q.push_back(model_rd(32'h1008));
    do_op(32'h1008, 1'b1, 4'h0, '0, 0, -1);
    exp_w = exp_q.pop_front();
    n_vec++;
    if (obs_dout !== exp_w || stall_cycles !== 0) begin
      n_err++; $display("FAIL st_merge_load got %h stall %0d want %h stall 0", obs_dout, stall_cycles, exp_w);
    end
  endtask

  task automatic test_store_miss();
    model[32'h2000] = 32'h1234_5678;
    do_op(32'h2000, 1'b0, 4'hF, 32'h1234_5678, 3, -1);
    n_vec++;
    if (unstable !== 1'b0) begin n_err++; $display("FAIL st_miss_stable got unstable want stable"); end
    n_vec++;
    if (stall_cycles !== 4) begin n_err++; $display("FAIL st_miss_stall got %0d want 4", stall_cycles); end
    n_vec++;
    if (n_wr !== 1 || wr_addr !== 32'h2000 || n_rd !== 0) begin
      n_err++; $display("FAIL st_miss_req got %0d wr addr %h %0d rd want 1 00002000 0", n_wr, wr_addr, n_rd);
    end
    exp_q.push_back(model_rd(32'h2000));
    do_op(32'h2000, 1'b1, 4'h0, '0, 0, -1);
    exp_w = exp_q.pop_front();
    n_vec++;
    if (n_rd !== 1 || obs_dout !== exp_w) begin
      n_err++; $display("FAIL st_noalloc got %0d reqs dout %h want 1 %h", n_rd, obs_dout, exp_w);
    end
  endtask

  task automatic test_evict();
    logic [31:0] seq [3];
    seq[0] = 32'h1000; seq[1] = 32'h2000; seq[2] = 32'h1008;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model_rd(seq[i]));
      do_op(seq[i], 1'b1, 4'h0, '0, 0, -1);
      exp_w = exp_q.pop_front();
      n_vec++;
      if (n_rd !== 1 || rd_addr !== (seq[i] & ~32'hF) || obs_dout !== exp_w) begin
        n_err++;
        $display("FAIL evict_%0d got %0d reqs addr %h dout %h want 1 %h %h",
                 i, n_rd, rd_addr, obs_dout, seq[i] & ~32'hF, exp_w);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(model_rd(32'h03FC));
    do_op(32'h03FC, 1'b1, 4'h0, '0, 0, -1);
    exp_w = exp_q.pop_front();
    n_vec++;
    if (n_rd !== 1 || rd_addr !== 32'h03F0 || obs_dout !== exp_w) begin
      n_err++; $display("FAIL wrap_miss got %0d reqs addr %h dout %h want 1 000003f0 %h",
                        n_rd, rd_addr, obs_dout, exp_w);
    end
    // Issued in the response cycle itself.
    exp_q.push_back(model_rd(32'h03F0));
    do_op(32'h03F0, 1'b1, 4'h0, '0, 0, -1);
    exp_w = exp_q.pop_front();
    n_vec++;
    if (stall_cycles !== 0 || n_rd !== 0 || obs_dout !== exp_w) begin
      n_err++; $display("FAIL b2b_hit got stall %0d reqs %0d dout %h want 0 0 %h",
                        stall_cycles, n_rd, obs_dout, exp_w);
    end
  endtask

  task automatic test_reset_mid_refill();
    do_op(32'h3010, 1'b1, 4'h0, '0, 0, 2);
    n_vec++;
    if (aborted !== 1'b1) begin n_err++; $display("FAIL abort_reach got %b want 1", aborted); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (bus.stall !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_reset got stall %b valid %b want 0 0", bus.stall, bus.mem_req_valid);
    end
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    n_vec++;
    if (bus.stall !== 1'b0 || bus.cpu_dout !== 32'h0) begin
      n_err++; $display("FAIL stray_beats got stall %b dout %h want 0 0", bus.stall, bus.cpu_dout);
    end
    exp_q.push_back(model_rd(32'h3010));
    do_op(32'h3010, 1'b1, 4'h0, '0, 0, -1);
    exp_w = exp_q.pop_front();
    n_vec++;
    if (n_rd !== 1 || rd_addr !== 32'h3010 || obs_dout !== exp_w) begin
      n_err++; $display("FAIL abort_refetch got %0d reqs addr %h dout %h want 1 00003010 %h",
                        n_rd, rd_addr, obs_dout, exp_w);
    end
  endtask

  initial begin
    for (int w = 0; w < 4; w++) begin
      bmem[32'h1000 + 32'(4 * w)]  = 32'hA0 + 32'(w);
      model[32'h1000 + 32'(4 * w)] = 32'hA0 + 32'(w);
    end
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_hit();
    test_store_miss();
    test_evict();
    test_back_to_back();
    test_reset_mid_refill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
